// File: rtl/elevator_car_plant.sv
// Plant model of an elevator car, shaft and door: turns controller motor/door
// commands into floor sensors and door status, and flags illegal command combinations.
module elevator_car_plant #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_BITS    = 2,
    parameter int TRAVEL_CYCLES = 20,
    parameter int DOOR_CYCLES   = 10,
    parameter int INIT_FLOOR    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  motor_up,
    input  logic                  motor_down,
    input  logic                  door_open,
    input  logic                  door_close,
    output logic [NUM_FLOORS-1:0] floor_sensors,
    output logic [FLOOR_BITS-1:0] car_floor,
    output logic                  between_floors,
    output logic                  door_closed,
    output logic                  door_opened,
    output logic                  door_moving,
    output logic [3:0]            fault
);

    localparam int POS_MAX  = (NUM_FLOORS - 1) * TRAVEL_CYCLES;
    localparam int POS_W    = (POS_MAX > 0) ? $clog2(POS_MAX + 1) : 1;
    localparam int CNT_W    = $clog2(DOOR_CYCLES);
    localparam int POS_INIT = INIT_FLOOR * TRAVEL_CYCLES;

    localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DOOR_CYCLES - 1);

    localparam int F_BOTH_MOTORS = 0;
    localparam int F_MOVE_DOOR   = 1;
    localparam int F_OVERTRAVEL  = 2;
    localparam int F_OPEN_UNSAFE = 3;

    typedef enum logic [1:0] {
        DOOR_CLOSED,
        DOOR_OPENING,
        DOOR_OPEN,
        DOOR_CLOSING
    } door_state_e;

    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    door_state_e      state_q, state_d;
    logic [3:0]       fault_q, fault_d;

    logic aligned;
    logic motor_any;
    logic door_shut;
    logic open_req_ok;
    logic at_top;
    logic at_bottom;

    // ------------------------------------------------------------------
    // Position decodes: one sensor per floor, lit only at exact alignment.
    // ------------------------------------------------------------------
    always_comb begin
        floor_sensors = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (int'(pos_q) == i * TRAVEL_CYCLES) begin
                floor_sensors[i] = 1'b1;
            end
        end
    end

    assign aligned        = |floor_sensors;
    assign between_floors = ~aligned;
    assign car_floor      = FLOOR_BITS'(int'(pos_q) / TRAVEL_CYCLES);
    assign at_top         = (pos_q == POS_MAX_V);
    assign at_bottom      = (pos_q == '0);

    assign motor_any   = motor_up | motor_down;
    assign door_shut   = (state_q == DOOR_CLOSED);
    // A door request is honoured only with the car parked at a floor.
    assign open_req_ok = door_open & aligned & ~motor_any;

    // ------------------------------------------------------------------
    // Car motion: a single clean motor command with the door shut moves
    // the car one step, clamped at the shaft ends.
    // ------------------------------------------------------------------
    always_comb begin
        pos_d = pos_q;
        if (door_shut && motor_up && !motor_down && !at_top) begin
            pos_d = pos_q + 1'b1;
        end else if (door_shut && motor_down && !motor_up && !at_bottom) begin
            pos_d = pos_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Door FSM next state.
    // ------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DOOR_CLOSED: begin
                if (open_req_ok) begin
                    state_d = DOOR_OPENING;
                    cnt_d   = '0;
                end
            end
            DOOR_OPENING: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DOOR_OPEN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (door_close && !door_open) begin
                    state_d = DOOR_CLOSING;
                    cnt_d   = '0;
                end
            end
            DOOR_CLOSING: begin
                // Safety reversal: a valid open request beats finishing the close.
                if (open_req_ok) begin
                    state_d = DOOR_OPENING;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOOR_CLOSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DOOR_CLOSED;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky violation flags.
    // ------------------------------------------------------------------
    always_comb begin
        fault_d = fault_q;
        if (motor_up && motor_down) begin
            fault_d[F_BOTH_MOTORS] = 1'b1;
        end
        if (motor_any && !door_shut) begin
            fault_d[F_MOVE_DOOR] = 1'b1;
        end
        if ((motor_up && at_top) || (motor_down && at_bottom)) begin
            fault_d[F_OVERTRAVEL] = 1'b1;
        end
        if (door_open && (!aligned || motor_any)) begin
            fault_d[F_OPEN_UNSAFE] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers with synchronous active-low reset.
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q   <= POS_INIT_V;
            cnt_q   <= '0;
            state_q <= DOOR_CLOSED;
            fault_q <= '0;
        end else begin
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign door_closed = (state_q == DOOR_CLOSED);
    assign door_opened = (state_q == DOOR_OPEN);
    assign door_moving = (state_q == DOOR_OPENING) || (state_q == DOOR_CLOSING);
    assign fault       = fault_q;

endmodule

// File: tb/tb_elevator_car_plant.sv
// Bench for elevator_car_plant: directed scenarios plus randomized commands
// compared against a cycle-level behavioural model of car, door and faults.
module tb_elevator_car_plant;

    localparam int NF   = 4;
    localparam int FB   = 2;
    localparam int TC   = 20;
    localparam int DC   = 10;
    localparam int INIT = 0;
    localparam int MAXP = (NF - 1) * TC;

    localparam int M_CLOSED  = 0;
    localparam int M_OPENING = 1;
    localparam int M_OPEN    = 2;
    localparam int M_CLOSING = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          motor_up, motor_down, door_open, door_close;
    logic [NF-1:0] floor_sensors;
    logic [FB-1:0] car_floor;
    logic          between_floors, door_closed, door_opened, door_moving;
    logic [3:0]    fault;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: position in steps, door mode plus remaining cycles.
    int         m_pos;
    int         m_mode;
    int         m_rem;
    logic [3:0] m_fault;

    elevator_car_plant #(
        .NUM_FLOORS(NF), .FLOOR_BITS(FB), .TRAVEL_CYCLES(TC),
        .DOOR_CYCLES(DC), .INIT_FLOOR(INIT)
    ) dut (
        .clk(clk), .reset(reset),
        .motor_up(motor_up), .motor_down(motor_down),
        .door_open(door_open), .door_close(door_close),
        .floor_sensors(floor_sensors), .car_floor(car_floor),
        .between_floors(between_floors), .door_closed(door_closed),
        .door_opened(door_opened), .door_moving(door_moving),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic rst, input logic up, input logic dn,
                                input logic op, input logic cl);
        bit aligned;
        bit any_m;
        bit open_ok;
        if (!rst) begin
            m_pos   = INIT * TC;
            m_mode  = M_CLOSED;
            m_rem   = 0;
            m_fault = 4'b0000;
            return;
        end
        aligned = (m_pos % TC) == 0;
        any_m   = up || dn;
        open_ok = op && aligned && !any_m;
        if (up && dn) m_fault[0] = 1'b1;
        if (any_m && m_mode != M_CLOSED) m_fault[1] = 1'b1;
        if ((up && m_pos == MAXP) || (dn && m_pos == 0)) m_fault[2] = 1'b1;
        if (op && (!aligned || any_m)) m_fault[3] = 1'b1;
        if (m_mode == M_CLOSED && up && !dn && m_pos < MAXP) m_pos++;
        else if (m_mode == M_CLOSED && dn && !up && m_pos > 0) m_pos--;
        case (m_mode)
            M_CLOSED: if (open_ok) begin m_mode = M_OPENING; m_rem = DC; end
            M_OPENING: begin
                m_rem--;
                if (m_rem == 0) m_mode = M_OPEN;
            end
            M_OPEN: if (cl && !op) begin m_mode = M_CLOSING; m_rem = DC; end
            default: begin
                if (open_ok) begin
                    m_mode = M_OPENING;
                    m_rem  = DC;
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_mode = M_CLOSED;
                end
            end
        endcase
    endtask

    // Apply one cycle of inputs, advance the model alongside the DUT, sample #1 later.
    task automatic step(input logic rst, input logic up, input logic dn,
                        input logic op, input logic cl);
        reset      = rst;
        motor_up   = up;
        motor_down = dn;
        door_open  = op;
        door_close = cl;
        @(posedge clk);
        model_update(rst, up, dn, op, cl);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (floor_sensors !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_sensors: got %b want 0001", floor_sensors);
        end
        n_checks++;
        if ({car_floor, between_floors} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_floor: got floor=%0d between=%b want 0/0", car_floor, between_floors);
        end
        n_checks++;
        if ({door_closed, door_opened, door_moving} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_door: got c/o/m=%b%b%b want 100", door_closed, door_opened, door_moving);
        end
        n_checks++;
        if (fault !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_fault: got %b want 0000", fault);
        end
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_travel;
        for (int k = 1; k <= TC; k++) begin
            step(1, 1, 0, 0, 0);
            if (k < TC) begin
                n_checks++;
                if (floor_sensors !== 4'b0000 || between_floors !== 1'b1) begin
                    n_errors++;
                    $display("FAIL travel_between edge %0d: got %b between=%b want 0000/1", k, floor_sensors, between_floors);
                end
            end
        end
        n_checks++;
        if (floor_sensors !== 4'b0010 || car_floor !== 2'd1) begin
            n_errors++;
            $display("FAIL travel_floor1: got %b floor=%0d want 0010 floor=1", floor_sensors, car_floor);
        end
        for (int k = 0; k < 2 * TC; k++) step(1, 1, 0, 0, 0);
        n_checks++;
        if (floor_sensors !== 4'b1000 || car_floor !== 2'd3) begin
            n_errors++;
            $display("FAIL travel_floor3: got %b floor=%0d want 1000 floor=3", floor_sensors, car_floor);
        end
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_door;
        step(1, 0, 0, 1, 0);
        for (int k = 1; k <= DC; k++) begin
            n_checks++;
            if (door_moving !== 1'b1 || door_opened !== 1'b0) begin
                n_errors++;
                $display("FAIL door_opening cycle %0d: got moving=%b opened=%b want 1/0", k, door_moving, door_opened);
            end
            if (k < DC) step(1, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (door_opened !== 1'b1 || door_moving !== 1'b0) begin
            n_errors++;
            $display("FAIL door_open_done: got opened=%b moving=%b want 1/0", door_opened, door_moving);
        end
        // Start closing, reverse on the 5th closing cycle.
        step(1, 0, 0, 0, 1);
        idle(4);
        step(1, 0, 0, 1, 0);
        idle(DC - 1);
        n_checks++;
        if (door_moving !== 1'b1 || door_opened !== 1'b0) begin
            n_errors++;
            $display("FAIL door_reopen_moving: got moving=%b opened=%b want 1/0", door_moving, door_opened);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (door_opened !== 1'b1) begin
            n_errors++;
            $display("FAIL door_reopened: got opened=%b want 1", door_opened);
        end
        step(1, 0, 0, 0, 1);
        idle(DC - 1);
        n_checks++;
        if (door_closed !== 1'b0 || door_moving !== 1'b1) begin
            n_errors++;
            $display("FAIL door_closing_late: got closed=%b moving=%b want 0/1", door_closed, door_moving);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (door_closed !== 1'b1 || door_moving !== 1'b0) begin
            n_errors++;
            $display("FAIL door_closed_final: got closed=%b moving=%b want 1/0", door_closed, door_moving);
        end
    endtask

    task automatic test_interlock;
        step(1, 0, 0, 1, 0);
        idle(DC);
        for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 0);
        n_checks++;
        if (floor_sensors !== 4'b1000 || fault[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL interlock: got sensors=%b fault=%b want 1000 fault[1]=1", floor_sensors, fault);
        end
        step(1, 0, 0, 0, 1);
        idle(DC);
        n_checks++;
        if (door_closed !== 1'b1 || fault[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL interlock_sticky: got closed=%b fault=%b want 1 fault[1]=1", door_closed, fault);
        end
    endtask

    task automatic test_faults;
        step(1, 1, 0, 0, 0);
        n_checks++;
        if (floor_sensors !== 4'b1000 || fault[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL overtravel: got sensors=%b fault=%b want 1000 fault[2]=1", floor_sensors, fault);
        end
        step(1, 1, 1, 0, 0);
        idle(5);
        n_checks++;
        if (fault !== 4'b0111 || floor_sensors !== 4'b1000) begin
            n_errors++;
            $display("FAIL faults_sticky: got fault=%b sensors=%b want 0111/1000", fault, floor_sensors);
        end
    endtask

    task automatic test_reset_midtravel;
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < TC + 7; k++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        n_checks++;
        if (fault !== 4'b1000 || door_closed !== 1'b1 || between_floors !== 1'b1) begin
            n_errors++;
            $display("FAIL open_between: got fault=%b closed=%b between=%b want 1000/1/1", fault, door_closed, between_floors);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (floor_sensors !== 4'b0001 || fault !== 4'b0000 || car_floor !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_midtravel: got sensors=%b fault=%b floor=%0d want 0001/0000/0", floor_sensors, fault, car_floor);
        end
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        logic       up, dn, op, cl, rst;
        logic [9:0] got, exp;
        bit         aligned;
        up = 0; dn = 0; op = 0; cl = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(7) == 0) begin
                up = ($urandom_range(9) < 4);
                dn = ($urandom_range(9) < 3);
                cl = ($urandom_range(9) < 2);
            end
            op  = ($urandom_range(11) == 0);
            rst = ($urandom_range(499) != 0);
            step(rst, up, dn, op, cl);
            aligned = (m_pos % TC) == 0;
            exp = {aligned ? 4'(1 << (m_pos / TC)) : 4'b0000, 2'(m_pos / TC), 1'b0, 3'b000};
            exp[3] = !aligned;
            exp[2] = (m_mode == M_CLOSED);
            exp[1] = (m_mode == M_OPEN);
            exp[0] = (m_mode == M_OPENING) || (m_mode == M_CLOSING);
            got = {floor_sensors, car_floor, between_floors, door_closed, door_opened, door_moving};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random_outputs cycle %0d: got %b want %b", n, got, exp);
            end
            n_checks++;
            if (fault !== m_fault) begin
                n_errors++;
                $display("FAIL random_fault cycle %0d: got %b want %b", n, fault, m_fault);
            end
        end
    endtask

    initial begin
        reset = 1'b0; motor_up = 1'b0; motor_down = 1'b0;
        door_open = 1'b0; door_close = 1'b0;
        m_pos = 0; m_mode = M_CLOSED; m_rem = 0; m_fault = 4'b0000;
        test_reset;
        test_travel;
        test_door;
        test_interlock;
        test_faults;
        test_reset_midtravel;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
